aes_ctr_axil_regs: RTL and testbench

AXI4-Lite responder (slave) register front end for the AES-CTR core. It is the peripheral end of the control-port transactions issued by the bus masters / VIP.
- Decodes byte offsets into a CTRL/CONFIG/STATUS/KEY/BLOCK/RESULT register map.
- Drives the core's init/next pulses and key/block/config buses.
- Captures the core result for read-back.
- Sits between the interconnect master port and the AES-CTR core, inside the scannable AES wrapper.

---
 rtl/aes_ctr_axil_regs.sv | 332 +++++++++++++++++++++++++++++++++
 tb/tb_aes_ctr_axil_regs.sv | 518 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ctr_axil_regs.sv
// AXI4-Lite register front end for the AES-CTR core.
// Ports: AXI4-Lite slave (aclk/areset, AW/W/B/AR/R) and core control/data buses.
module aes_ctr_axil_regs #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]              s_axi_awprot,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [3:0]              s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]              s_axi_arprot,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic                    core_init,
  output logic                    core_next,
  output logic                    core_encdec,
  output logic                    core_keylen,
  output logic [255:0]            core_key,
  output logic [127:0]            core_block,
  input  logic                    core_ready,
  input  logic [127:0]            core_result,
  input  logic                    core_result_valid
);

  localparam logic [0:0] WR_IDLE = 1'b0;
  localparam logic [0:0] WR_RESP = 1'b1;
  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_DATA = 1'b1;
  localparam logic [1:0] OKAY    = 2'b00;
  localparam logic [1:0] SLVERR  = 2'b10;

  logic [0:0]            wr_state_q, wr_state_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  have_aw_q, have_aw_d;
  logic                  have_w_q, have_w_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;

  logic [0:0]            rd_state_q, rd_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic [1:0]            config_q, config_d;
  logic [31:0]           key_q [8];
  logic [31:0]           key_d [8];
  logic [31:0]           blk_q [4];
  logic [31:0]           blk_d [4];
  logic [31:0]           res_q [4];
  logic [31:0]           res_d [4];
  logic                  resv_q, resv_d;
  logic                  rvprev_q;
  logic                  init_q, init_d;
  logic                  next_q, next_d;

  logic                  unused_prot;
  assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  s
  );
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[b*8 +: 8] = s[b] ? nw[b*8 +: 8] : old[b*8 +: 8];
    return r;
  endfunction

  // Effective write beat: a held beat, or one arriving this cycle.
  logic                  aw_hs, w_hs, aw_have, w_have;
  logic [ADDR_WIDTH-1:0] wa;
  logic [31:0]           wd;
  logic [3:0]            ws;
  logic [7:0]            woff;
  logic [5:0]            widx;
  logic [2:0]            wk;
  logic [1:0]            wb;

  assign aw_hs   = s_axi_awvalid & awready_q;
  assign w_hs    = s_axi_wvalid & wready_q;
  assign aw_have = have_aw_q | aw_hs;
  assign w_have  = have_w_q | w_hs;
  assign wa      = have_aw_q ? awaddr_q : s_axi_awaddr;
  assign wd      = have_w_q ? wdata_q : s_axi_wdata;
  assign ws      = have_w_q ? wstrb_q : s_axi_wstrb;
  assign woff    = wa[7:0];
  assign widx    = woff[7:2];
  assign wk      = 3'(widx - 6'd6);
  assign wb      = 2'(widx - 6'd14);

  always_comb begin
    wr_state_d = wr_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    have_aw_d  = have_aw_q;
    have_w_d   = have_w_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    config_d   = config_q;
    key_d      = key_q;
    blk_d      = blk_q;
    init_d     = 1'b0;
    next_d     = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs) begin
          have_aw_d = 1'b1;
          awaddr_d  = s_axi_awaddr;
          awready_d = 1'b0;
        end
        if (w_hs) begin
          have_w_d = 1'b1;
          wdata_d  = s_axi_wdata;
          wstrb_d  = s_axi_wstrb;
          wready_d = 1'b0;
        end
        if (aw_have && w_have) begin
          have_aw_d  = 1'b0;
          have_w_d   = 1'b0;
          awready_d  = 1'b0;
          wready_d   = 1'b0;
          bvalid_d   = 1'b1;
          wr_state_d = WR_RESP;
          bresp_d    = SLVERR;
          if (woff[1:0] == 2'b00) begin
            if (widx == 6'd0) begin
              bresp_d = OKAY;
              if (ws[0] && (wd[1:0] != 2'b00)) begin
                if (!core_ready) begin
                  bresp_d = SLVERR;
                end else begin
                  // init takes priority over next
                  init_d = wd[0];
                  next_d = wd[1] & ~wd[0];
                end
              end
            end else if (widx == 6'd1) begin
              bresp_d = OKAY;
              if (ws[0]) config_d = wd[1:0];
            end else if (widx >= 6'd6 && widx <= 6'd13) begin
              bresp_d   = OKAY;
              key_d[wk] = merge(key_q[wk], wd, ws);
            end else if (widx >= 6'd14 && widx <= 6'd17) begin
              bresp_d   = OKAY;
              blk_d[wb] = merge(blk_q[wb], wd, ws);
            end
          end
        end
      end
      default: begin
        if (s_axi_bready) begin
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
          wr_state_d = WR_IDLE;
        end
      end
    endcase
  end

  // Result latch: cleared when a pulse is launched, else set on rising valid.
  always_comb begin
    res_d  = res_q;
    resv_d = resv_q;
    if (init_d || next_d) begin
      resv_d = 1'b0;
      for (int i = 0; i < 4; i++) res_d[i] = '0;
    end else if (core_result_valid && !rvprev_q) begin
      resv_d = 1'b1;
      for (int i = 0; i < 4; i++) res_d[i] = core_result[127-32*i -: 32];
    end
  end

  logic [7:0]  roff;
  logic [5:0]  ridx;
  logic [2:0]  rk;
  logic [1:0]  rb;
  logic [1:0]  rr;
  logic [31:0] rmux;
  logic        rerr;

  assign roff = s_axi_araddr[7:0];
  assign ridx = roff[7:2];
  assign rk   = 3'(ridx - 6'd6);
  assign rb   = 2'(ridx - 6'd14);
  assign rr   = 2'(ridx - 6'd18);

  always_comb begin
    rmux = '0;
    rerr = 1'b1;
    if (roff[1:0] == 2'b00) begin
      if (ridx == 6'd0) begin
        rerr = 1'b0;
      end else if (ridx == 6'd1) begin
        rerr = 1'b0;
        rmux = {30'd0, config_q};
      end else if (ridx == 6'd2) begin
        rerr = 1'b0;
        rmux = {30'd0, resv_q, core_ready};
      end else if (ridx >= 6'd6 && ridx <= 6'd13) begin
        rerr = 1'b0;
        rmux = key_q[rk];
      end else if (ridx >= 6'd14 && ridx <= 6'd17) begin
        rerr = 1'b0;
        rmux = blk_q[rb];
      end else if (ridx >= 6'd18 && ridx <= 6'd21) begin
        rerr = 1'b0;
        rmux = res_q[rr];
      end
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (s_axi_arvalid && arready_q) begin
          rdata_d    = rmux;
          rresp_d    = rerr ? SLVERR : OKAY;
          rvalid_d   = 1'b1;
          arready_d  = 1'b0;
          rd_state_d = RD_DATA;
        end
      end
      default: begin
        if (s_axi_rready) begin
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
          rd_state_d = RD_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state_q <= WR_IDLE;
      awready_q  <= 1'b1;
      wready_q   <= 1'b1;
      have_aw_q  <= 1'b0;
      have_w_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= OKAY;
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= OKAY;
      config_q   <= '0;
      for (int i = 0; i < 8; i++) key_q[i] <= '0;
      for (int i = 0; i < 4; i++) blk_q[i] <= '0;
      for (int i = 0; i < 4; i++) res_q[i] <= '0;
      resv_q     <= 1'b0;
      rvprev_q   <= 1'b0;
      init_q     <= 1'b0;
      next_q     <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      have_aw_q  <= have_aw_d;
      have_w_q   <= have_w_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      config_q   <= config_d;
      key_q      <= key_d;
      blk_q      <= blk_d;
      res_q      <= res_d;
      resv_q     <= resv_d;
      rvprev_q   <= core_result_valid;
      init_q     <= init_d;
      next_q     <= next_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) core_key[255-32*i -: 32] = key_q[i];
    for (int i = 0; i < 4; i++) core_block[127-32*i -: 32] = blk_q[i];
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign core_init     = init_q;
  assign core_next     = next_q;
  assign core_encdec   = config_q[0];
  assign core_keylen   = config_q[1];

endmodule

// File: tb/tb_aes_ctr_axil_regs.sv
// Self-checking bench for aes_ctr_axil_regs.
// Directed scenarios plus randomized register traffic against a map model.
module tb_aes_ctr_axil_regs;

  logic         aclk = 1'b0;
  logic         areset;
  logic [7:0]   s_axi_awaddr;
  logic [2:0]   s_axi_awprot;
  logic         s_axi_awvalid;
  logic         s_axi_awready;
  logic [31:0]  s_axi_wdata;
  logic [3:0]   s_axi_wstrb;
  logic         s_axi_wvalid;
  logic         s_axi_wready;
  logic [1:0]   s_axi_bresp;
  logic         s_axi_bvalid;
  logic         s_axi_bready;
  logic [7:0]   s_axi_araddr;
  logic [2:0]   s_axi_arprot;
  logic         s_axi_arvalid;
  logic         s_axi_arready;
  logic [31:0]  s_axi_rdata;
  logic [1:0]   s_axi_rresp;
  logic         s_axi_rvalid;
  logic         s_axi_rready;
  logic         core_init;
  logic         core_next;
  logic         core_encdec;
  logic         core_keylen;
  logic [255:0] core_key;
  logic [127:0] core_block;
  logic         core_ready;
  logic [127:0] core_result;
  logic         core_result_valid;

  int vectors = 0;
  int errors  = 0;
  int n_init  = 0;
  int n_next  = 0;
  int n_bhs   = 0;

  logic [31:0] m_key [8];
  logic [31:0] m_blk [4];
  logic [31:0] m_res [4];
  logic [1:0]  m_cfg;
  logic        m_rv;

  aes_ctr_axil_regs dut (
    .aclk(aclk), .areset(areset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .core_init(core_init), .core_next(core_next),
    .core_encdec(core_encdec), .core_keylen(core_keylen),
    .core_key(core_key), .core_block(core_block),
    .core_ready(core_ready), .core_result(core_result),
    .core_result_valid(core_result_valid)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    if (core_init) n_init++;
    if (core_next) n_next++;
    if (s_axi_bvalid && s_axi_bready) n_bhs++;
  end

  function automatic void mdl_clear();
    m_cfg = 2'b00;
    m_rv  = 1'b0;
    for (int i = 0; i < 8; i++) m_key[i] = '0;
    for (int i = 0; i < 4; i++) m_blk[i] = '0;
    for (int i = 0; i < 4; i++) m_res[i] = '0;
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  function automatic void mdl_wr(input int off, input logic [31:0] d,
                                 input logic [3:0] s, output logic [1:0] r);
    logic [31:0] m;
    m = strb_mask(s);
    r = 2'b10;
    if (off % 4 != 0) return;
    if (off == 0) begin
      r = 2'b00;
      if (s[0] && d[1:0] != 2'b00) begin
        if (!core_ready) begin
          r = 2'b10;
        end else begin
          m_rv = 1'b0;
          for (int i = 0; i < 4; i++) m_res[i] = '0;
        end
      end
    end else if (off == 4) begin
      r = 2'b00;
      if (s[0]) m_cfg = d[1:0];
    end else if (off >= 'h18 && off <= 'h34) begin
      r = 2'b00;
      m_key[(off - 'h18) / 4] = (m_key[(off - 'h18) / 4] & ~m) | (d & m);
    end else if (off >= 'h38 && off <= 'h44) begin
      r = 2'b00;
      m_blk[(off - 'h38) / 4] = (m_blk[(off - 'h38) / 4] & ~m) | (d & m);
    end
  endfunction

  function automatic void mdl_rd(input int off, output logic [31:0] d,
                                 output logic [1:0] r);
    d = '0;
    r = 2'b10;
    if (off % 4 != 0) return;
    if (off == 0) r = 2'b00;
    else if (off == 4) begin r = 2'b00; d = {30'd0, m_cfg}; end
    else if (off == 8) begin r = 2'b00; d = {30'd0, m_rv, core_ready}; end
    else if (off >= 'h18 && off <= 'h34) begin
      r = 2'b00; d = m_key[(off - 'h18) / 4];
    end else if (off >= 'h38 && off <= 'h44) begin
      r = 2'b00; d = m_blk[(off - 'h38) / 4];
    end else if (off >= 'h48 && off <= 'h54) begin
      r = 2'b00; d = m_res[(off - 'h48) / 4];
    end
  endfunction

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] r);
    bit a_h, w_h, a_done, w_done;
    int n;
    a_done = 0; w_done = 0; n = 0;
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    while (!(a_done && w_done) && n < 20) begin
      a_h = s_axi_awvalid && s_axi_awready;
      w_h = s_axi_wvalid && s_axi_wready;
      @(posedge aclk); #1;
      if (a_h) begin a_done = 1; s_axi_awvalid = 1'b0; end
      if (w_h) begin w_done = 1; s_axi_wvalid = 1'b0; end
      n++;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b1;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin @(posedge aclk); #1; n++; end
    if (!s_axi_bvalid) begin
      vectors++; errors++;
      $display("FAIL wr_timeout addr %h bvalid %b want 1", a, s_axi_bvalid);
      r = 2'b11;
    end else begin
      r = s_axi_bresp;
    end
    @(posedge aclk); #1;
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d,
                          output logic [1:0] r);
    int n;
    n = 0;
    s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    while (!s_axi_arready && n < 20) begin @(posedge aclk); #1; n++; end
    @(posedge aclk); #1;
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin @(posedge aclk); #1; n++; end
    if (!s_axi_rvalid) begin
      vectors++; errors++;
      $display("FAIL rd_timeout addr %h rvalid %b want 1", a, s_axi_rvalid);
      d = 'x; r = 2'b11;
    end else begin
      d = s_axi_rdata; r = s_axi_rresp;
    end
    @(posedge aclk); #1;
    s_axi_rready = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    mdl_clear();
    vectors++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
      errors++;
      $display("FAIL reset_ready got %b want 111",
               {s_axi_awready, s_axi_wready, s_axi_arready});
    end
    vectors++;
    if ({s_axi_bvalid, s_axi_rvalid, s_axi_bresp, s_axi_rresp} !== 6'd0) begin
      errors++;
      $display("FAIL reset_resp got %b want 000000",
               {s_axi_bvalid, s_axi_rvalid, s_axi_bresp, s_axi_rresp});
    end
    vectors++;
    if ({s_axi_rdata, core_init, core_next} !== 34'd0) begin
      errors++;
      $display("FAIL reset_rdata_pulse got %h want 0",
               {s_axi_rdata, core_init, core_next});
    end
    vectors++;
    if ({core_key, core_block, core_encdec, core_keylen} !== 386'd0) begin
      errors++;
      $display("FAIL reset_core got %h want 0", {core_key, core_block});
    end
    areset = 1'b0;
    @(posedge aclk); #1;
  endtask

  task automatic test_key_load();
    logic [31:0] kv [8];
    logic [31:0] d;
    logic [1:0]  r;
    kv[0] = 32'h2b7e1516; kv[1] = 32'h28aed2a6;
    kv[2] = 32'habf71588; kv[3] = 32'h09cf4f3c;
    for (int i = 4; i < 8; i++) kv[i] = '0;
    for (int i = 0; i < 8; i++) begin
      axi_write(8'(8'h18 + 4 * i), kv[i], 4'hf, r);
      vectors++;
      if (r !== 2'b00) begin
        errors++;
        $display("FAIL key_bresp idx %0d got %b want 00", i, r);
      end
    end
    vectors++;
    if (core_key !== 256'h2b7e151628aed2a6abf7158809cf4f3c_00000000000000000000000000000000) begin
      errors++;
      $display("FAIL key_bus got %h", core_key);
    end
    axi_read(8'h1c, d, r);
    vectors++;
    if (d !== 32'h28aed2a6 || r !== 2'b00) begin
      errors++;
      $display("FAIL key_readback got %h/%b want 28aed2a6/00", d, r);
    end
    for (int i = 0; i < 8; i++) m_key[i] = kv[i];
  endtask

  task automatic test_init_next();
    logic [1:0]  r;
    logic [31:0] bv [4];
    int ni, nn;
    core_ready = 1'b1;
    axi_write(8'h04, 32'h1, 4'hf, r);
    m_cfg = 2'b01;
    ni = n_init; nn = n_next;
    axi_write(8'h00, 32'h1, 4'hf, r);
    vectors++;
    if (r !== 2'b00) begin
      errors++; $display("FAIL init_bresp got %b want 00", r);
    end
    axi_write(8'h00, 32'h0, 4'hf, r);
    repeat (2) @(posedge aclk);
    #1;
    vectors++;
    if (core_encdec !== 1'b1 || n_init - ni !== 1 || n_next - nn !== 0) begin
      errors++;
      $display("FAIL init_pulse got encdec %b init %0d next %0d want 1/1/0",
               core_encdec, n_init - ni, n_next - nn);
    end
    bv[0] = 32'h6bc1bee2; bv[1] = 32'h2e409f96;
    bv[2] = 32'he93d7e11; bv[3] = 32'h7393172a;
    for (int i = 0; i < 4; i++) begin
      axi_write(8'(8'h38 + 4 * i), bv[i], 4'hf, r);
      m_blk[i] = bv[i];
    end
    ni = n_init; nn = n_next;
    axi_write(8'h00, 32'h2, 4'hf, r);
    repeat (2) @(posedge aclk);
    #1;
    vectors++;
    if (r !== 2'b00 || n_init - ni !== 0 || n_next - nn !== 1) begin
      errors++;
      $display("FAIL next_pulse got resp %b init %0d next %0d want 00/0/1",
               r, n_init - ni, n_next - nn);
    end
    vectors++;
    if (core_block !== 128'h6bc1bee22e409f96e93d7e117393172a) begin
      errors++; $display("FAIL block_bus got %h", core_block);
    end
    ni = n_init; nn = n_next;
    axi_write(8'h00, 32'h3, 4'hf, r);
    repeat (2) @(posedge aclk);
    #1;
    vectors++;
    if (r !== 2'b00 || n_init - ni !== 1 || n_next - nn !== 0) begin
      errors++;
      $display("FAIL both_bits got resp %b init %0d next %0d want 00/1/0",
               r, n_init - ni, n_next - nn);
    end
  endtask

  task automatic test_result();
    logic [31:0] d, e;
    logic [1:0]  r, er;
    logic [127:0] rv;
    rv = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    core_result = rv;
    core_result_valid = 1'b1;
    for (int i = 0; i < 4; i++) m_res[i] = rv[127-32*i -: 32];
    m_rv = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    axi_read(8'h08, d, r);
    vectors++;
    if (d !== 32'h3 || r !== 2'b00) begin
      errors++; $display("FAIL status_set got %h/%b want 3/00", d, r);
    end
    axi_read(8'h48, d, r);
    vectors++;
    if (d !== 32'h3ad77bb4) begin
      errors++; $display("FAIL result0 got %h want 3ad77bb4", d);
    end
    axi_read(8'h54, d, r);
    vectors++;
    if (d !== 32'h2466ef97) begin
      errors++; $display("FAIL result3 got %h want 2466ef97", d);
    end
    axi_write(8'h48, 32'hdeadbeef, 4'hf, r);
    mdl_wr('h48, 32'hdeadbeef, 4'hf, er);
    axi_read(8'h48, d, r);
    mdl_rd('h48, e, er);
    vectors++;
    if (d !== e) begin
      errors++; $display("FAIL result_ro got %h want %h", d, e);
    end
    axi_write(8'h00, 32'h2, 4'hf, r);
    mdl_wr(0, 32'h2, 4'hf, er);
    axi_read(8'h08, d, r);
    vectors++;
    if (d !== 32'h1) begin
      errors++; $display("FAIL status_clear got %h want 1", d);
    end
    core_result_valid = 1'b0;
  endtask

  task automatic test_errors();
    logic [31:0] d;
    logic [1:0]  r;
    int ni, nn;
    axi_write(8'h48, 32'h1234, 4'hf, r);
    vectors++;
    if (r !== 2'b10) begin
      errors++; $display("FAIL ro_write got %b want 10", r);
    end
    axi_read(8'h60, d, r);
    vectors++;
    if (d !== 32'h0 || r !== 2'b10) begin
      errors++; $display("FAIL unmapped_rd got %h/%b want 0/10", d, r);
    end
    core_ready = 1'b0;
    ni = n_init; nn = n_next;
    axi_write(8'h00, 32'h1, 4'hf, r);
    repeat (2) @(posedge aclk);
    #1;
    vectors++;
    if (r !== 2'b10 || n_init - ni !== 0 || n_next - nn !== 0) begin
      errors++;
      $display("FAIL busy_ctrl got %b init %0d want 10/0", r, n_init - ni);
    end
    core_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [1:0]  r;
    int nb;
    bit bad;
    nb = n_bhs;
    bad = 0;
    s_axi_wdata = 32'hffffff02; s_axi_wstrb = 4'b0001;
    s_axi_awaddr = 8'h04; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
    @(posedge aclk); #1;
    s_axi_wvalid = 1'b0;
    vectors++;
    if (s_axi_wready !== 1'b0 || s_axi_awready !== 1'b1) begin
      errors++;
      $display("FAIL w_first_ready got w %b aw %b want 0/1",
               s_axi_wready, s_axi_awready);
    end
    repeat (2) @(posedge aclk);
    #1;
    s_axi_awvalid = 1'b1;
    @(posedge aclk); #1;
    s_axi_awvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00 ||
          s_axi_awready !== 1'b0) bad = 1;
      @(posedge aclk); #1;
    end
    vectors++;
    if (bad) begin
      errors++; $display("FAIL b_hold got unstable bvalid/bresp want held 1/00");
    end
    s_axi_bready = 1'b1;
    @(posedge aclk); #1;
    s_axi_bready = 1'b0;
    vectors++;
    if ({s_axi_bvalid, s_axi_awready, s_axi_wready} !== 3'b011 ||
        n_bhs - nb !== 1) begin
      errors++;
      $display("FAIL b_release got %b hs %0d want 011/1",
               {s_axi_bvalid, s_axi_awready, s_axi_wready}, n_bhs - nb);
    end
    mdl_wr(4, 32'hffffff02, 4'b0001, r);
    axi_write(8'h04, 32'h3, 4'b1110, r);
    mdl_wr(4, 32'h3, 4'b1110, r);
    axi_read(8'h04, d, r);
    vectors++;
    if (d !== {30'd0, m_cfg} || d !== 32'h2) begin
      errors++; $display("FAIL cfg_strobe got %h want 2", d);
    end
  endtask

  task automatic test_random();
    logic [31:0] d, e, wd;
    logic [1:0]  r, er;
    logic [3:0]  ws;
    int off, bad;
    bad = 0;
    for (int n = 0; n < 150; n++) begin
      off = 4 * $urandom_range(0, 24);
      if ($urandom_range(0, 9) == 0) off = off + $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) begin
        if (off == 0) off = 4;
        wd = $urandom;
        ws = 4'($urandom);
        mdl_wr(off, wd, ws, er);
        axi_write(8'(off), wd, ws, r);
        if (r !== er) begin
          bad++;
          $display("FAIL rnd_bresp off %h got %b want %b", off, r, er);
        end
      end else begin
        mdl_rd(off, e, er);
        axi_read(8'(off), d, r);
        if (d !== e || r !== er) begin
          bad++;
          $display("FAIL rnd_read off %h got %h/%b want %h/%b", off, d, r, e, er);
        end
      end
    end
    vectors++;
    if (bad != 0) errors++;
    vectors++;
    if (core_key !== {m_key[0], m_key[1], m_key[2], m_key[3],
                      m_key[4], m_key[5], m_key[6], m_key[7]} ||
        core_block !== {m_blk[0], m_blk[1], m_blk[2], m_blk[3]} ||
        {core_keylen, core_encdec} !== m_cfg) begin
      errors++;
      $display("FAIL rnd_buses got key %h blk %h cfg %b", core_key, core_block,
               {core_keylen, core_encdec});
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] d;
    logic [1:0]  r;
    int n, bad;
    bad = 0;
    n = 0;
    s_axi_awaddr = 8'h20; s_axi_wdata = 32'h55aa55aa; s_axi_wstrb = 4'hf;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
    @(posedge aclk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    while (!s_axi_bvalid && n < 10) begin @(posedge aclk); #1; n++; end
    vectors++;
    if (s_axi_bvalid !== 1'b1) begin
      errors++; $display("FAIL mid_bvalid got %b want 1", s_axi_bvalid);
    end
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    mdl_clear();
    vectors++;
    if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset got bvalid %b awready %b want 0/1",
               s_axi_bvalid, s_axi_awready);
    end
    for (int i = 0; i < 8; i++) begin
      axi_read(8'(8'h18 + 4 * i), d, r);
      if (d !== m_key[i]) begin
        bad++; $display("FAIL mid_key idx %0d got %h want 0", i, d);
      end
    end
    vectors++;
    if (bad != 0) errors++;
  endtask

  initial begin
    areset = 1'b1;
    s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0;
    s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    core_ready = 1'b1;
    core_result = '0;
    core_result_valid = 1'b0;
    test_reset();
    test_key_load();
    test_init_next();
    test_result();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
